// File: rtl/wb_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with a word-wide backing-memory port.
// Optional hit/miss counters are enabled by defining WB_CACHE_STATS_EN.
module wb_cache_ctrl #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready
`ifdef WB_CACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 13 - IW;

    typedef enum logic [1:0] {IDLE, WB, FILL, RETRY} state_t;

    state_t          state_q;
    logic [1:0]      cnt_q;
    logic [15:0]     addr_q, wdata_q;
    logic            rd_q, wr_q;
    logic [LINES-1:0] valid_q, dirty_q;
    logic [TW-1:0]   tag_mem [LINES];
    logic [15:0]     data_mem [LINES*WORDS];

    logic [IW-1:0]   req_idx, lat_idx;
    logic [TW-1:0]   req_tag, lat_tag;
    logic [1:0]      req_word, lat_word;
    logic            req, illegal, hit;
    logic            unused_bits;

    assign req_idx  = Addr[2+IW:3];
    assign req_tag  = Addr[15:3+IW];
    assign req_word = Addr[2:1];
    assign lat_idx  = addr_q[2+IW:3];
    assign lat_tag  = addr_q[15:3+IW];
    assign lat_word = addr_q[2:1];
    assign unused_bits = ^{createdump, addr_q[0]};

    assign req     = Rd | Wr;
    assign illegal = (Rd & Wr) | (req & Addr[0]);
    assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign Stall   = (state_q == WB) || (state_q == FILL);

    // Hits and errors complete in the request cycle, so completion is decoded combinationally.
    always_comb begin
        Done      = 1'b0;
        CacheHit  = 1'b0;
        err       = 1'b0;
        DataOut   = 16'h0000;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (illegal) begin
                    Done = 1'b1;
                    err  = 1'b1;
                end else if (req && hit) begin
                    Done     = 1'b1;
                    CacheHit = 1'b1;
                    if (Rd) DataOut = data_mem[{req_idx, req_word}];
                end
            end
            WB: begin
                mem_wr    = 1'b1;
                mem_addr  = {tag_mem[lat_idx], lat_idx, cnt_q, 1'b0};
                mem_wdata = data_mem[{lat_idx, cnt_q}];
            end
            FILL: begin
                mem_rd   = 1'b1;
                mem_addr = {lat_tag, lat_idx, cnt_q, 1'b0};
            end
            RETRY: begin
                Done = 1'b1;
                if (rd_q) DataOut = data_mem[{lat_idx, lat_word}];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && !illegal && !hit) begin
                        addr_q  <= Addr;
                        wdata_q <= DataIn;
                        rd_q    <= Rd;
                        wr_q    <= Wr;
                        cnt_q   <= 2'd0;
                        state_q <= (valid_q[req_idx] && dirty_q[req_idx]) ? WB : FILL;
                    end else if (Wr && !illegal && hit) begin
                        dirty_q[req_idx] <= 1'b1;
                    end
                end
                WB: begin
                    if (mem_ready) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) state_q <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            valid_q[lat_idx] <= 1'b1;
                            dirty_q[lat_idx] <= 1'b0;
                            state_q          <= RETRY;
                        end
                    end
                end
                RETRY: begin
                    if (wr_q) dirty_q[lat_idx] <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            case (state_q)
                IDLE: if (Wr && !illegal && hit) data_mem[{req_idx, req_word}] <= DataIn;
                FILL: if (mem_ready) begin
                    data_mem[{lat_idx, cnt_q}] <= mem_rdata;
                    if (cnt_q == 2'd3) tag_mem[lat_idx] <= lat_tag;
                end
                RETRY: if (wr_q) data_mem[{lat_idx, lat_word}] <= wdata_q;
                default: ;
            endcase
        end
    end

`ifdef WB_CACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
        end else if (Done && !err) begin
            if (CacheHit) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Directed bench for wb_cache_ctrl: request scoreboard plus a backing-memory model that
// checks every word transfer against an expected-transfer queue.
module tb_wb_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn;
    logic        Rd, Wr;
    logic        createdump;
    logic [15:0] DataOut;
    logic        Done, Stall, CacheHit, err;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
`ifdef WB_CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    wb_cache_ctrl dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
        .CacheHit(CacheHit), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef WB_CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic        err;
        logic [15:0] data;
        int          cycles;
    } exp_t;

    exp_t        exp_q[$];
    logic [32:0] mem_exp[$];
    logic [15:0] mem [32768];
    int          total = 0;
    int          passed = 0;
    int          ready_delay = 0;
    int          wait_cnt = 0;
    logic [15:0] hold_addr;

    function automatic logic [15:0] init_val(input int i);
        logic [15:0] v;
        v = 16'(i);
        return (v * 16'h0101) ^ 16'h3C3C;
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        total = total + 1;
        assert (obs === expv) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic exp_fill(input logic [15:0] base);
        for (int i = 0; i < 4; i++) mem_exp.push_back({1'b0, 16'(base + 16'(2*i)), 16'h0000});
    endtask

    task automatic exp_wb(input logic [15:0] base, input logic [15:0] d0, d1, d2, d3);
        mem_exp.push_back({1'b1, base,          d0});
        mem_exp.push_back({1'b1, base + 16'd2,  d1});
        mem_exp.push_back({1'b1, base + 16'd4,  d2});
        mem_exp.push_back({1'b1, base + 16'd6,  d3});
    endtask

    // Backing memory: answers after ready_delay idle cycles and logs each completed transfer.
    always @(negedge clk) begin
        logic [32:0] e;
        if (mem_rd || mem_wr) begin
            check("mem_rd_wr_excl", 48'(mem_rd & mem_wr), 48'd0);
            if (wait_cnt == 0) hold_addr = mem_addr;
            else check("mem_addr_hold", 48'(mem_addr), 48'(hold_addr));
            if (wait_cnt == ready_delay) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[15:1]];
                wait_cnt  = 0;
                e = (mem_exp.size() != 0) ? mem_exp.pop_front() : 33'h1_FFFF_FFFF;
                check("mem_xfer", 48'({mem_wr, mem_addr, mem_wr ? mem_wdata : 16'h0000}), 48'(e));
                if (mem_wr) mem[mem_addr[15:1]] = mem_wdata;
            end else begin
                mem_ready = 1'b0;
                wait_cnt  = wait_cnt + 1;
            end
        end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end
    end

    task automatic request(input string tag, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [15:0] wd,
                           input logic e_hit, input logic e_err,
                           input logic [15:0] e_data, input int e_cycles);
        exp_t        e;
        int          cyc;
        bit          got, stall_bad;
        logic        o_hit, o_err, o_stall;
        logic [15:0] o_data;
        exp_q.push_back('{e_hit, e_err, e_data, e_cycles});
        Addr = a; DataIn = wd; Rd = rd; Wr = wr;
        cyc = 0; got = 0; stall_bad = 0;
        o_hit = 1'b0; o_err = 1'b0; o_stall = 1'b0; o_data = 16'h0000;
        while (!got && cyc <= 200) begin
            @(negedge clk);
            if (Done) begin
                got = 1; o_hit = CacheHit; o_err = err; o_stall = Stall; o_data = DataOut;
            end else begin
                if (cyc > 0 && !Stall) stall_bad = 1;
                @(posedge clk);
                cyc++;
            end
        end
        e = exp_q.pop_front();
        $display("req %s addr=%h rd=%0d wr=%0d done=%0d cycles=%0d hit=%0d err=%0d data=%h",
                 tag, a, rd, wr, got, cyc, o_hit, o_err, o_data);
        check({tag, "_done"},   48'(got), 48'd1);
        check({tag, "_cycles"}, 48'(cyc), 48'(e.cycles));
        check({tag, "_hit"},    48'(o_hit), 48'(e.hit));
        check({tag, "_err"},    48'(o_err), 48'(e.err));
        check({tag, "_stall"},  48'({o_stall, stall_bad}), 48'd0);
        if (rd && !e.err) check({tag, "_data"}, 48'(o_data), 48'(e.data));
        @(posedge clk);
        #1;
        Rd = 1'b0; Wr = 1'b0;
        check({tag, "_xfers_left"}, 48'(mem_exp.size()), 48'd0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = init_val(i);
        mem[16'h0044 >> 1] = 16'hBEEF;
        rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000; DataIn = 16'h0000;
        createdump = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", 48'({Done, CacheHit, err, Stall, mem_rd, mem_wr}), 48'd0);
        check("reset_data", 48'({DataOut, mem_addr, mem_wdata}), 48'd0);
        rst = 1'b0;

        // Cold read, then hits and a write hit on the filled line.
        exp_fill(16'h0040);
        request("cold_rd", 1, 0, 16'h0044, 16'h0000, 0, 0, 16'hBEEF, 5);
        request("rehit",   1, 0, 16'h0044, 16'h0000, 1, 0, 16'hBEEF, 0);
        request("wr_hit",  0, 1, 16'h0042, 16'h1234, 1, 0, 16'h0000, 0);
        request("rd_hit",  1, 0, 16'h0042, 16'h0000, 1, 0, 16'h1234, 0);

        // Conflict on index 8 forces a dirty write-back before the fill.
        exp_wb(16'h0040, init_val(16'h20), 16'h1234, 16'hBEEF, init_val(16'h23));
        exp_fill(16'h0440);
        request("dirty_miss", 1, 0, 16'h0440, 16'h0000, 0, 0, init_val(16'h220), 9);

        // Illegal requests: no traffic, no array change.
        request("misalign", 1, 0, 16'h0041, 16'h0000, 0, 1, 16'h0000, 0);
        request("rd_and_wr", 1, 1, 16'h0440, 16'hDEAD, 0, 1, 16'h0000, 0);
        request("after_ill", 1, 0, 16'h0440, 16'h0000, 1, 0, init_val(16'h220), 0);

        // Write miss allocates, then its dirty line is evicted by another tag.
        exp_fill(16'h0080);
        request("wr_miss",  0, 1, 16'h0086, 16'h5555, 0, 0, 16'h0000, 5);
        request("wr_miss_rd", 1, 0, 16'h0086, 16'h0000, 1, 0, 16'h5555, 0);
        exp_wb(16'h0080, init_val(16'h40), init_val(16'h41), init_val(16'h42), 16'h5555);
        exp_fill(16'h0000);
        request("evict_wmiss", 1, 0, 16'h0006, 16'h0000, 0, 0, init_val(16'h3), 9);

        // Slow memory: three idle cycles before each word.
        ready_delay = 3;
        exp_fill(16'h0108);
        request("slow_fill", 1, 0, 16'h0108, 16'h0000, 0, 0, init_val(16'h84), 17);
        ready_delay = 0;

        // Reset during the second fill word abandons the request.
        mem_exp.push_back({1'b0, 16'h0048, 16'h0000});
        mem_exp.push_back({1'b0, 16'h004A, 16'h0000});
        Addr = 16'h0048; Rd = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1; Rd = 1'b0;
        @(negedge clk);
        check("rst_mid_no_done", 48'(Done), 48'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_idle", 48'({mem_rd, mem_wr, Stall, Done}), 48'd0);
        check("rst_mid_xfers", 48'(mem_exp.size()), 48'd0);
        $display("req rst_mid_fill addr=0048 abandoned");
        exp_fill(16'h0440);
        request("post_rst_miss", 1, 0, 16'h0440, 16'h0000, 0, 0, init_val(16'h220), 5);

`ifdef WB_CACHE_STATS_EN
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("stats_rst", 48'({hit_count, miss_count}), 48'd0);
        exp_fill(16'h0040);
        request("st_miss", 1, 0, 16'h0044, 16'h0000, 0, 0, 16'hBEEF, 5);
        for (int i = 0; i < 3; i++)
            request("st_hit", 1, 0, 16'h0044, 16'h0000, 1, 0, 16'hBEEF, 0);
        request("st_err", 1, 0, 16'h0045, 16'h0000, 0, 1, 16'h0000, 0);
        check("stats_hits",   48'(hit_count),  48'd3);
        check("stats_misses", 48'(miss_count), 48'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("stats_clr", 48'({hit_count, miss_count}), 48'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
